// File: rtl/counter_sequencer.sv
// Sequencer for an enable-less 4-bit up/down counter: loads a start value, lets it run
// for a commanded number of steps, checks the landing value and holds it by re-loading.
module counter_sequencer #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_start,
    input  logic             cmd_dir,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_abort,
    input  logic [3:0]       cnt_q,
    output logic             load,
    output logic             mode,
    output logic [3:0]       din,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state;
    logic             dir;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] remaining;
    logic [3:0]       expected;
    logic [3:0]       cnt_step;

    // Value the counter takes on the edge where an abort is honoured.
    assign cnt_step = dir ? cnt_q + 4'd1 : cnt_q - 4'd1;

    // Outputs are registered alongside the state so each reflects the state being entered.
    // In IDLE, din carries the hold value that keeps the counter still.
    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            dir       <= 1'b0;
            len       <= '0;
            remaining <= '0;
            expected  <= 4'd0;
            err       <= 1'b0;
            load      <= 1'b1;
            din       <= 4'd0;
            mode      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= LOAD;
                        dir       <= cmd_dir;
                        len       <= cmd_len;
                        expected  <= cmd_dir ? cmd_start + 4'(cmd_len)
                                             : cmd_start - 4'(cmd_len);
                        load      <= 1'b1;
                        din       <= cmd_start;
                        mode      <= cmd_dir;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    if (len == '0) begin
                        state <= DONE;
                        load  <= 1'b1;
                        din   <= expected;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state     <= RUN;
                        remaining <= len;
                        load      <= 1'b0;
                    end
                end
                RUN: begin
                    if (cmd_abort) begin
                        // Abort wins over completion; hold where the counter lands this edge.
                        state     <= IDLE;
                        remaining <= '0;
                        load      <= 1'b1;
                        din       <= cnt_step;
                        mode      <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else if (remaining == LEN_W'(1)) begin
                        state     <= DONE;
                        remaining <= '0;
                        load      <= 1'b1;
                        din       <= expected;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    mode      <= 1'b0;
                    cmd_ready <= 1'b1;
                    if (cnt_q != expected) begin
                        err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench pairing counter_sequencer with a behavioural up/down counter; table-driven runs
// plus hand sequences for abort, mismatch, reset mid-run and back-to-back commands.
module tb_counter_sequencer;

    logic       clock = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_start;
    logic       cmd_dir;
    logic [7:0] cmd_len;
    logic       cmd_abort;
    logic [3:0] cnt_q;
    logic       load;
    logic       mode;
    logic [3:0] din;
    logic       busy;
    logic       done;
    logic       err;
    logic       skip;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    counter_sequencer #(.LEN_W(8)) dut (
        .clock(clock), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_len(cmd_len),
        .cmd_abort(cmd_abort), .cnt_q(cnt_q), .load(load), .mode(mode),
        .din(din), .busy(busy), .done(done), .err(err)
    );

    // Counter model; skip suppresses one counting step to create a mismatch.
    always_ff @(posedge clock) begin
        if (rst)        cnt_q <= 4'd0;
        else if (load)  cnt_q <= din;
        else if (!skip) cnt_q <= mode ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end

    typedef struct {
        logic [3:0] start;
        logic       dir;
        logic [7:0] len;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offer a command at a falling edge; returns at the falling edge inside LOAD.
    task automatic issue(input logic [3:0] s, input logic d, input logic [7:0] l, input logic keep);
        check("ready_before_cmd", int'(cmd_ready), 1);
        cmd_start = s; cmd_dir = d; cmd_len = l; cmd_valid = 1'b1;
        @(negedge clock);
        if (!keep) cmd_valid = 1'b0;
    endtask

    // Called in LOAD (cycle 1); returns at the falling edge where done is high.
    task automatic wait_done(output int cyc, output int busy_n, output int cq);
        int ok;
        ok = 0; cyc = 1; busy_n = 0; cq = -1;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1; cq = int'(cnt_q);
                break;
            end
            if (busy) busy_n++;
            @(negedge clock);
            cyc++;
        end
        if (ok == 0) check("done_timeout", 0, 1);
    endtask

    task automatic run_vec(input vec_t v, input int exp_err);
        int cyc, bn, cq;
        issue(v.start, v.dir, v.len, 1'b0);
        wait_done(cyc, bn, cq);
        check("done_cycle", cyc, int'(v.len) + 2);
        check("busy_cycles", bn, int'(v.len) + 1);
        check("cnt_at_done", cq, int'(v.exp));
        @(negedge clock);
        check("hold_din", int'(din), int'(v.exp));
        check("hold_cnt", int'(cnt_q), int'(v.exp));
        check("idle_done_low", int'(done), 0);
        check("err_after_run", int'(err), exp_err);
    endtask

    initial begin
        int cyc, bn, cq;
        vecs[0] = '{start: 4'd3,  dir: 1'b1, len: 8'd5,  exp: 4'd8};
        vecs[1] = '{start: 4'd2,  dir: 1'b0, len: 8'd4,  exp: 4'd14};
        vecs[2] = '{start: 4'd9,  dir: 1'b1, len: 8'd0,  exp: 4'd9};
        vecs[3] = '{start: 4'd15, dir: 1'b1, len: 8'd1,  exp: 4'd0};
        vecs[4] = '{start: 4'd0,  dir: 1'b0, len: 8'd17, exp: 4'd15};
        vecs[5] = '{start: 4'd7,  dir: 1'b1, len: 8'd16, exp: 4'd7};

        rst = 1'b1; cmd_valid = 1'b0; cmd_start = 4'd0; cmd_dir = 1'b0;
        cmd_len = 8'd0; cmd_abort = 1'b0; skip = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_load", int'(load), 1);
        check("rst_din", int'(din), 0);
        check("rst_busy_done", int'({busy, done, err, mode}), 0);
        check("rst_ready", int'(cmd_ready), 1);
        rst = 1'b0;
        @(negedge clock);

        foreach (vecs[i]) run_vec(vecs[i], 0);

        // Abort on RUN cycle 3 with the counter at 2: hold at 3, no done pulse.
        issue(4'd0, 1'b1, 8'd20, 1'b0);
        repeat (3) @(negedge clock);
        check("abort_cnt_before", int'(cnt_q), 2);
        cmd_abort = 1'b1;
        @(negedge clock);
        cmd_abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_hold", int'(din), 3);
        check("abort_load", int'(load), 1);
        check("abort_cnt", int'(cnt_q), 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("abort_no_done", int'(done), 0);
            check("abort_cnt_still", int'(cnt_q), 3);
        end

        // Abort offered in LOAD is ignored.
        issue(4'd4, 1'b1, 8'd2, 1'b0);
        cmd_abort = 1'b1;
        @(negedge clock);
        cmd_abort = 1'b0;
        wait_done(cyc, bn, cq);
        check("load_abort_ignored", cq, 6);
        @(negedge clock);

        // Counter skips a step: err sets after DONE and sticks through a good run.
        issue(4'd1, 1'b1, 8'd3, 1'b0);
        @(negedge clock);
        skip = 1'b1;
        @(negedge clock);
        skip = 1'b0;
        wait_done(cyc, bn, cq);
        check("mm_cnt_at_done", cq, 3);
        @(negedge clock);
        check("mm_err_set", int'(err), 1);
        check("mm_hold_expected", int'(din), 4);
        run_vec(vecs[0], 1);

        // Reset mid-RUN with a command already offered; accepted only after rst drops.
        issue(4'd5, 1'b1, 8'd10, 1'b0);
        repeat (2) @(negedge clock);
        rst = 1'b1;
        cmd_start = 4'd3; cmd_dir = 1'b1; cmd_len = 8'd2; cmd_valid = 1'b1;
        @(negedge clock);
        check("rr_load", int'(load), 1);
        check("rr_din", int'(din), 0);
        check("rr_err", int'(err), 0);
        check("rr_ready", int'(cmd_ready), 1);
        check("rr_busy_done", int'({busy, done}), 0);
        @(negedge clock);
        check("rr_held_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clock);
        check("rr_accept_busy", int'(busy), 1);
        check("rr_accept_din", int'(din), 3);
        cmd_valid = 1'b0;
        wait_done(cyc, bn, cq);
        check("rr_cnt_at_done", cq, 5);
        @(negedge clock);

        // Back-to-back: cmd_valid held, re-accepted in the first IDLE cycle.
        issue(4'd10, 1'b0, 8'd3, 1'b1);
        wait_done(cyc, bn, cq);
        check("b2b_first", cq, 7);
        @(negedge clock);
        check("b2b_idle_ready", int'(cmd_ready), 1);
        @(negedge clock);
        check("b2b_second_busy", int'(busy), 1);
        cmd_valid = 1'b0;
        wait_done(cyc, bn, cq);
        check("b2b_second", cq, 7);
        check("b2b_cycles", cyc, 5);
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
